// File: rtl/y_operand_stage.sv
// Y-operand stage at the ID/EX boundary.
// Selects the ALU second operand from register B, shamt, zero, an extended
// immediate or a LUI-shifted immediate. B is forwarded from EX/MEM or MEM/WB.
// The result is held in a one-entry valid/ready register that supports flush.
// A saturating counter records how many accepted operands were forwarded.
module y_operand_stage #(
  parameter int          DATA_W  = 32,
  parameter logic [4:0]  ZEXT_OP = 5'b00110,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] b_reg,
  input  logic [4:0]        b_num,
  input  logic [2:0]        y_sel,
  input  logic              exm_wr,
  input  logic [4:0]        exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_wr,
  input  logic [4:0]        mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  input  logic              flush,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_out,
  output logic [1:0]        y_fwd,
  output logic [CNT_W-1:0]  fwd_cnt
);

  logic              accept;
  logic [15:0]       imm;
  logic [4:0]        sh;
  logic [31:0]       lui32;
  logic              hit_exm;
  logic              hit_mwb;
  logic [DATA_W-1:0] sel_y;
  logic [1:0]        sel_fwd;
  logic              unused_instr;

  assign imm    = instruction[15:0];
  assign sh     = instruction[10:6];
  assign lui32  = {imm, 16'h0000};

  // Bits [26:16] carry register fields that this stage does not decode.
  assign unused_instr = ^instruction[26:16];

  // Register 0 is hard-wired, so it is never a forwarding target.
  assign hit_exm = exm_wr && (exm_rd == b_num) && (b_num != 5'd0);
  assign hit_mwb = mwb_wr && (mwb_rd == b_num) && (b_num != 5'd0);

  // A single stage that can refill in the same cycle it drains.
  assign in_ready = !y_valid || y_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Operand selection and forwarding source for the incoming instruction.
  always_comb begin
    sel_y   = '0;
    sel_fwd = 2'd0;
    case (y_sel)
      3'd0: begin
        if (hit_exm) begin
          sel_y   = exm_data;
          sel_fwd = 2'd1;
        end else if (hit_mwb) begin
          sel_y   = mwb_data;
          sel_fwd = 2'd2;
        end else begin
          sel_y   = b_reg;
        end
      end
      3'd1: sel_y[4:0] = sh;
      3'd3: begin
        if (instruction[31:27] != ZEXT_OP) begin
          sel_y = {DATA_W{imm[15]}};
        end
        sel_y[15:0] = imm;
      end
      3'd4: begin
        sel_y       = {DATA_W{imm[15]}};
        sel_y[15:0] = imm;
      end
      3'd5: sel_y[15:0] = imm;
      3'd6: begin
        // Sign-extend the LUI result above bit 31 on wide datapaths.
        sel_y       = {DATA_W{lui32[31]}};
        sel_y[31:0] = lui32;
      end
      default: begin
        sel_y   = '0;
        sel_fwd = 2'd0;
      end
    endcase
  end

  // Pipeline register; flush outranks accept, and data holds when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_out   <= '0;
      y_fwd   <= 2'd0;
    end else if (flush) begin
      y_valid <= 1'b0;
    end else if (accept) begin
      y_valid <= 1'b1;
      y_out   <= sel_y;
      y_fwd   <= sel_fwd;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

  // Forwarded-operand counter; it sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt <= '0;
    end else if (accept && (sel_fwd != 2'd0) && (fwd_cnt != {CNT_W{1'b1}})) begin
      fwd_cnt <= fwd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_y_operand_stage.sv
module tb_y_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [31:0] instruction;
  logic [31:0] b_reg;
  logic [4:0]  b_num;
  logic [2:0]  y_sel;
  logic        exm_wr;
  logic [4:0]  exm_rd;
  logic [31:0] exm_data;
  logic        mwb_wr;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_data;
  logic        flush;
  logic        y_valid, y_valid2;
  logic        y_ready;
  logic [31:0] y_out, y_out2;
  logic [1:0]  y_fwd, y_fwd2;
  logic [15:0] fwd_cnt;
  logic [1:0]  fwd_cnt2;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_valid;
  logic [31:0] m_y;
  logic [1:0]  m_fwd;
  int          m_cnt;
  int          m_cnt2;

  always #5 clk = ~clk;

  y_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .b_reg(b_reg), .b_num(b_num), .y_sel(y_sel),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .flush(flush), .y_valid(y_valid), .y_ready(y_ready), .y_out(y_out),
    .y_fwd(y_fwd), .fwd_cnt(fwd_cnt)
  );

  y_operand_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .instruction(instruction), .b_reg(b_reg), .b_num(b_num), .y_sel(y_sel),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .flush(flush), .y_valid(y_valid2), .y_ready(y_ready), .y_out(y_out2),
    .y_fwd(y_fwd2), .fwd_cnt(fwd_cnt2)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] breg;
    logic [4:0]  bnum;
    logic        ewr;
    logic [4:0]  erd;
    logic [31:0] edata;
    logic        mwr;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic [31:0] exp_y;
    logic [1:0]  exp_fwd;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Operand value straight from the selection rules, using plain arithmetic.
  task automatic ref_y(output logic [31:0] y, output logic [1:0] f);
    int unsigned imm, sh, op;
    imm = instruction & 32'hFFFF;
    sh  = (instruction >> 6) % 32;
    op  = instruction >> 27;
    y = 0;
    f = 0;
    case (y_sel)
      3'd0: begin
        if (b_num != 0 && exm_wr && exm_rd == b_num) begin y = exm_data; f = 1; end
        else if (b_num != 0 && mwb_wr && mwb_rd == b_num) begin y = mwb_data; f = 2; end
        else y = b_reg;
      end
      3'd1: y = sh;
      3'd2: y = 0;
      3'd3: y = (op == 6 || imm < 32768) ? imm : imm + 32'hFFFF_0000;
      3'd4: y = (imm < 32768) ? imm : imm + 32'hFFFF_0000;
      3'd5: y = imm;
      3'd6: y = imm * 65536;
      default: y = 0;
    endcase
  endtask

  task automatic model_reset();
    m_valid = 0; m_y = 0; m_fwd = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // One clock: check in_ready, clock, advance model, check outputs.
  task automatic step();
    logic        acc;
    logic [31:0] ny;
    logic [1:0]  nf;
    #1;
    chk("in_ready", in_ready, !m_valid || y_ready);
    chk("in_ready_sat", in_ready2, !m_valid || y_ready);
    ref_y(ny, nf);
    acc = in_valid && (!m_valid || y_ready) && !flush;
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_y = ny; m_fwd = nf;
      if (nf != 0) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end else if (y_ready) m_valid = 0;
    #1;
    chk("y_valid", y_valid, m_valid);
    chk("y_out", y_out, m_y);
    chk("y_fwd", y_fwd, m_fwd);
    chk("fwd_cnt", fwd_cnt, m_cnt);
    chk("y_valid_sat", y_valid2, m_valid);
    chk("y_out_sat", y_out2, m_y);
    chk("y_fwd_sat", y_fwd2, m_fwd);
    chk("fwd_cnt_sat", fwd_cnt2, m_cnt2);
  endtask

  task automatic quiet();
    in_valid = 0; instruction = 0; b_reg = 0; b_num = 0; y_sel = 0;
    exm_wr = 0; exm_rd = 0; exm_data = 0; mwb_wr = 0; mwb_rd = 0; mwb_data = 0;
    flush = 0; y_ready = 1;
  endtask

  task automatic load_vec(input vec_t v);
    instruction = v.instr; y_sel = v.sel; b_reg = v.breg; b_num = v.bnum;
    exm_wr = v.ewr; exm_rd = v.erd; exm_data = v.edata;
    mwb_wr = v.mwr; mwb_rd = v.mrd; mwb_data = v.mdata;
  endtask

  task automatic fwd_hit(input logic [31:0] d);
    y_sel = 0; b_num = 5'd8; b_reg = 32'h0;
    exm_wr = 1; exm_rd = 5'd8; exm_data = d; mwb_wr = 0;
  endtask

  initial begin
    logic [31:0] held;
    int          saved_cnt;
    int          sat_exp[5];

    sat_exp = '{1, 2, 3, 3, 3};
    tbl[0]  = '{32'h3000_8001, 3'd3, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0000_8001, 2'd0};
    tbl[1]  = '{32'h2000_8001, 3'd3, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hFFFF_8001, 2'd0};
    tbl[2]  = '{32'h0000_1234, 3'd6, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h1234_0000, 2'd0};
    tbl[3]  = '{32'h0000_07C0, 3'd1, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd31,        2'd0};
    tbl[4]  = '{32'h3000_8000, 3'd4, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hFFFF_8000, 2'd0};
    tbl[5]  = '{32'hFFFF_F00F, 3'd5, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0000_F00F, 2'd0};
    tbl[6]  = '{32'hFFFF_FFFF, 3'd2, 32'h1111_2222, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0};
    tbl[7]  = '{32'hFFFF_FFFF, 3'd7, 32'h1111_2222, 5'd8, 1'b1, 5'd8, 32'hAAAA_AAAA, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0};
    tbl[8]  = '{32'h0, 3'd0, 32'h1357_9BDF, 5'd8, 1'b1, 5'd8, 32'hAAAA_AAAA, 1'b1, 5'd8, 32'h5555_5555, 32'hAAAA_AAAA, 2'd1};
    tbl[9]  = '{32'h0, 3'd0, 32'h1357_9BDF, 5'd8, 1'b0, 5'd8, 32'hAAAA_AAAA, 1'b1, 5'd8, 32'h5555_5555, 32'h5555_5555, 2'd2};
    tbl[10] = '{32'h0, 3'd0, 32'h1357_9BDF, 5'd0, 1'b1, 5'd0, 32'hAAAA_AAAA, 1'b1, 5'd0, 32'h5555_5555, 32'h1357_9BDF, 2'd0};
    tbl[11] = '{32'h0, 3'd0, 32'h2468_ACE0, 5'd5, 1'b1, 5'd6, 32'hAAAA_AAAA, 1'b1, 5'd4, 32'h5555_5555, 32'h2468_ACE0, 2'd0};

    quiet();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    chk("reset y_valid", y_valid, 1'b0);
    chk("reset y_out", y_out, 32'h0);
    chk("reset y_fwd", y_fwd, 2'd0);
    chk("reset fwd_cnt", fwd_cnt, 16'd0);

    // table vectors, one accept per cycle
    in_valid = 1;
    for (int i = 0; i < 12; i++) begin
      load_vec(tbl[i]);
      step();
      chk($sformatf("tbl%0d valid", i), y_valid, 1'b1);
      chk($sformatf("tbl%0d y_out", i), y_out, tbl[i].exp_y);
      chk($sformatf("tbl%0d y_fwd", i), y_fwd, tbl[i].exp_fwd);
      if (i == 8) chk("tbl8 fwd_cnt", fwd_cnt, 16'd1);
    end

    // backpressure: held operand stays put, then next one loads with no bubble
    quiet();
    in_valid = 1; y_sel = 3'd5; instruction = 32'h0000_00A1;
    step();
    held = y_out;
    chk("bp first", held, 32'h0000_00A1);
    y_ready = 0; instruction = 32'h0000_00B2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp in_ready", in_ready, 1'b0);
      chk("bp stable", y_out, held);
    end
    y_ready = 1;
    step();
    chk("bp next", y_out, 32'h0000_00B2);
    instruction = 32'h0000_00C3;
    step();
    chk("bp after", y_out, 32'h0000_00C3);
    in_valid = 0;
    step();
    chk("bp drain", y_valid, 1'b0);

    // flush while holding, with a forwarding hit on the dropped instruction
    in_valid = 1; instruction = 32'h0000_00D4;
    step();
    saved_cnt = fwd_cnt;
    y_ready = 0; flush = 1;
    fwd_hit(32'hDEAD_BEEF);
    step();
    chk("flush valid", y_valid, 1'b0);
    chk("flush cnt", fwd_cnt, saved_cnt);
    chk("flush y_out", y_out, 32'h0000_00D4);
    flush = 0; y_ready = 1;

    // async reset mid-cycle while valid
    fwd_hit(32'hCAFE_F00D);
    step();
    chk("pre-reset valid", y_valid, 1'b1);
    #2;
    rst_n = 0;
    #1;
    chk("async y_valid", y_valid, 1'b0);
    chk("async y_out", y_out, 32'h0);
    chk("async fwd_cnt", fwd_cnt, 16'd0);
    chk("async fwd_cnt_sat", fwd_cnt2, 2'd0);
    model_reset();
    #1;
    rst_n = 1;
    step();
    chk("post-reset y_out", y_out, 32'hCAFE_F00D);
    chk("post-reset fwd_cnt", fwd_cnt, 16'd1);

    // saturation on the 2-bit counter after a fresh reset
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    model_reset();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      fwd_hit(32'h100 + i);
      step();
      chk($sformatf("sat %0d", i), fwd_cnt2, sat_exp[i]);
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      y_ready     = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 9) == 0);
      instruction = $urandom;
      if ($urandom_range(0, 3) == 0) instruction[31:27] = 5'b00110;
      y_sel       = 3'($urandom_range(0, 7));
      b_reg       = $urandom;
      b_num       = 5'($urandom_range(0, 3));
      exm_wr      = 1'($urandom_range(0, 1));
      exm_rd      = 5'($urandom_range(0, 3));
      exm_data    = $urandom;
      mwb_wr      = 1'($urandom_range(0, 1));
      mwb_rd      = 5'($urandom_range(0, 3));
      mwb_data    = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y_operand_stage.md
Name: y_operand_stage

Overview:
- Registered, parametrised successor to the combinational ALU Y-operand selector. Sits at the ID/EX boundary of the 5-stage pipeline.
- Per instruction, it selects the ALU second operand from one of: register B, shamt, zero, auto/sign/zero-extended immediate, or LUI-shifted immediate.
- It resolves B-operand RAW hazards by forwarding from EX/MEM and MEM/WB.
- It holds the result in a one-entry valid/ready pipeline register with flush support, and keeps a saturating count of forwarded operands.

Parameters:
- DATA_W, 32, operand width; legal values are 32 or greater.
- ZEXT_OP, 5'b00110, value of instruction[31:27] that selects zero-extension in auto-immediate mode (ori/andi).
- CNT_W, 16, width of the forwarding-event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- instruction  in  32  instruction word.
- b_reg  in  DATA_W  register-file value of the B operand.
- b_num  in  5  register number of the B operand.
- y_sel  in  3  0=B, 1=shamt, 2=zero, 3=imm auto, 4=imm sign, 5=imm zero, 6=lui, 7=reserved.
- exm_wr  in  1  EX/MEM writes a register.
- exm_rd  in  5  EX/MEM destination register.
- exm_data  in  DATA_W  EX/MEM result.
- mwb_wr  in  1  MEM/WB writes a register.
- mwb_rd  in  5  MEM/WB destination register.
- mwb_data  in  DATA_W  MEM/WB result.
- flush  in  1  kill the held and incoming instruction.
- y_valid  out  1  y_out holds a valid operand.
- y_ready  in  1  downstream (EX) accepts this cycle.
- y_out  out  DATA_W  registered Y operand.
- y_fwd  out  2  source of the held operand: 0=none, 1=EX/MEM, 2=MEM/WB.
- fwd_cnt  out  CNT_W  saturating count of accepted forwarded operands.

Behaviour:
- Reset (rst_n=0, asynchronous): y_valid=0, y_out=0, y_fwd=0, fwd_cnt=0. This holds mid-transfer too; the held instruction is lost.
- in_ready = !y_valid | y_ready. This is combinational and gives a bubble-collapsing single stage.
- accept = in_valid & in_ready & !flush. Latency is 1 cycle: an operand accepted in cycle N is presented in cycle N+1.
- On accept: y_out and y_fwd are loaded from the selection below, and y_valid is set to 1.
- Else if y_ready=1 (and no accept): y_valid is cleared to 0. y_out and y_fwd hold.
- Else: all state holds. y_out stays stable while y_valid=1 and y_ready=0.
- flush=1: y_valid is cleared to 0 next cycle regardless of y_ready. Any incoming instruction is dropped and fwd_cnt is unchanged. Flush wins over a simultaneous accept.
- Selection (imm = instruction[15:0]; sh = instruction[10:6]):
  - y_sel 0: forwarded B.
  - y_sel 1: sh zero-extended to DATA_W.
  - y_sel 2: zero.
  - y_sel 3: zero-extend if instruction[31:27]==ZEXT_OP, otherwise sign-extend.
  - y_sel 4: imm sign-extended (bit 15 replicated).
  - y_sel 5: imm zero-extended.
  - y_sel 6: {imm,16'b0} in bits [31:0], with bit 31 sign-extended above when DATA_W>32.
  - y_sel 7: zero, with y_fwd=0.
- Forwarding applies only when y_sel=0 and b_num!=0:
  - If exm_wr and exm_rd==b_num: take exm_data, y_fwd=1.
  - Else if mwb_wr and mwb_rd==b_num: take mwb_data, y_fwd=2.
  - Else: take b_reg, y_fwd=0.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded, even when a write to rd=0 is asserted.
  - Forwarding inputs are sampled only in the accept cycle.
- fwd_cnt increments on each accept with y_fwd!=0. It saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.

Test Plan:
- Immediate modes:
  - instruction=0x3000_8001, y_sel=3 → y_out=0x0000_8001 (ZEXT_OP hit).
  - instruction=0x2000_8001, y_sel=3 → y_out=0xFFFF_8001.
  - y_sel=6, imm=0x1234 → y_out=0x1234_0000.
  - y_sel=1, instruction[10:6]=5'd31 → y_out=31.
  - Each result appears exactly one cycle after accept.
- Forwarding priority:
  - b_num=8, exm (wr,rd=8,data=0xAAAA_AAAA), mwb (wr,rd=8,data=0x5555_5555), y_sel=0 → y_out=0xAAAA_AAAA, y_fwd=1, fwd_cnt=1.
  - Drop exm_wr → y_out=0x5555_5555, y_fwd=2.
  - b_num=0 with exm rd=0 → y_out=b_reg, y_fwd=0.
- Backpressure: hold y_ready=0 for 3 cycles with in_valid=1 → in_ready=0, y_out stable. Raise y_ready → next operand loaded the following cycle with no bubble and no duplicate.
- Flush: flush=1 with y_valid=1, y_ready=0, in_valid=1 → next cycle y_valid=0 and the incoming instruction is not captured; fwd_cnt is unchanged even if the dropped instruction hit forwarding.
- Saturation: CNT_W=2, five forwarded accepts → fwd_cnt reads 1,2,3,3,3.
- Async reset: assert rst_n=0 mid-cycle while y_valid=1 → y_valid, y_out and fwd_cnt read 0 immediately, without waiting for a clock edge. Deassert rst_n → first accept behaves normally.
